// File: rtl/tt_accum_pkg.sv
// rtl/tt_accum_pkg.sv - shared opcode encoding for the accumulate unit
package tt_accum_pkg;

  localparam int OP_W = 2;

  typedef enum logic [OP_W-1:0] {
    OP_ADD = 2'd0,
    OP_SUB = 2'd1,
    OP_ACC = 2'd2,
    OP_CLR = 2'd3
  } op_e;

endpackage

// File: rtl/tt_sat_addsub.sv
// rtl/tt_sat_addsub.sv - combinational unsigned add/subtract with optional saturation
//   x, y    : operands (W bits, unsigned)
//   sub     : 1 = x - y, 0 = x + y
//   sat_en  : clamp to all-ones on carry / zero on borrow instead of wrapping
//   value   : W-bit result
//   cb      : carry out (add) or borrow (sub)
module tt_sat_addsub #(
  parameter int W = 8
) (
  input  logic [W-1:0] x,
  input  logic [W-1:0] y,
  input  logic         sub,
  input  logic         sat_en,
  output logic [W-1:0] value,
  output logic         cb
);

  logic [W:0] ext;

  // One extra bit holds the carry; for subtraction it goes high exactly when x < y.
  always_comb begin
    ext = sub ? ({1'b0, x} - {1'b0, y}) : ({1'b0, x} + {1'b0, y});
    cb  = ext[W];
    if (sat_en && cb) begin
      value = sub ? '0 : '1;
    end else begin
      value = ext[W-1:0];
    end
  end

endmodule

// File: rtl/tt_accum_unit.sv
// rtl/tt_accum_unit.sv - two-stage add/sub/accumulate/clear unit with valid/ready handshake
//   clk, rst_n            : clock, asynchronous active-low reset
//   ena                   : global enable, low freezes all state
//   in_valid/in_ready     : operation handshake for op, sat_en, a, b
//   out_valid/out_ready   : result handshake for result, ovf
//   acc                   : registered accumulator value
module tt_accum_unit
  import tt_accum_pkg::*;
#(
  parameter int WIDTH     = 8,
  parameter int ACC_WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 ena,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [OP_W-1:0]      op,
  input  logic                 sat_en,
  input  logic [WIDTH-1:0]     a,
  input  logic [WIDTH-1:0]     b,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [WIDTH-1:0]     result,
  output logic                 ovf,
  output logic [ACC_WIDTH-1:0] acc
);

  // Stage 1: captured operation
  logic             s1_valid_q;
  op_e              s1_op_q;
  logic             s1_sat_q;
  logic [WIDTH-1:0] s1_a_q;
  logic [WIDTH-1:0] s1_b_q;

  // Stage 2: output register and accumulator
  logic                 out_valid_q;
  logic [WIDTH-1:0]     result_q, result_d;
  logic                 ovf_q, ovf_d;
  logic [ACC_WIDTH-1:0] acc_q, acc_d;

  logic advance;
  logic accept;

  assign advance  = ena && s1_valid_q && (!out_valid_q || out_ready);
  assign in_ready = ena && (!s1_valid_q || advance);
  assign accept   = in_valid && in_ready;

  // Byte-wide ADD/SUB path
  logic [WIDTH-1:0] w_val;
  logic             w_cb;

  tt_sat_addsub #(.W(WIDTH)) u_addsub_w (
    .x      (s1_a_q),
    .y      (s1_b_q),
    .sub    (s1_op_q == OP_SUB),
    .sat_en (s1_sat_q),
    .value  (w_val),
    .cb     (w_cb)
  );

  // Accumulate path: a+b never exceeds WIDTH+1 bits, so adding it to acc as one
  // zero-extended operand gives exactly acc+a+b with a single carry out.
  logic [WIDTH:0]       ab_sum;
  logic [ACC_WIDTH-1:0] acc_val;
  logic                 acc_cb;

  assign ab_sum = {1'b0, s1_a_q} + {1'b0, s1_b_q};

  tt_sat_addsub #(.W(ACC_WIDTH)) u_addsub_acc (
    .x      (acc_q),
    .y      (ACC_WIDTH'(ab_sum)),
    .sub    (1'b0),
    .sat_en (s1_sat_q),
    .value  (acc_val),
    .cb     (acc_cb)
  );

  always_comb begin
    result_d = w_val;
    ovf_d    = w_cb;
    acc_d    = acc_q;
    case (s1_op_q)
      OP_ADD, OP_SUB: begin
        result_d = w_val;
        ovf_d    = w_cb;
      end
      OP_ACC: begin
        acc_d = acc_val;
        ovf_d = acc_cb;
        // Saturating result clamps when the new accumulator no longer fits the result width.
        if (s1_sat_q && (|acc_val[ACC_WIDTH-1:WIDTH])) begin
          result_d = '1;
        end else begin
          result_d = acc_val[WIDTH-1:0];
        end
      end
      OP_CLR: begin
        acc_d    = '0;
        result_d = '0;
        ovf_d    = 1'b0;
      end
      default: begin
        result_d = w_val;
        ovf_d    = w_cb;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid_q <= 1'b0;
      s1_op_q    <= OP_ADD;
      s1_sat_q   <= 1'b0;
      s1_a_q     <= '0;
      s1_b_q     <= '0;
    end else if (ena) begin
      if (accept) begin
        s1_valid_q <= 1'b1;
        s1_op_q    <= op_e'(op);
        s1_sat_q   <= sat_en;
        s1_a_q     <= a;
        s1_b_q     <= b;
      end else if (advance) begin
        s1_valid_q <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q <= 1'b0;
      result_q    <= '0;
      ovf_q       <= 1'b0;
      acc_q       <= '0;
    end else if (advance) begin
      out_valid_q <= 1'b1;
      result_q    <= result_d;
      ovf_q       <= ovf_d;
      acc_q       <= acc_d;
    end else if (ena && out_ready) begin
      out_valid_q <= 1'b0;
    end
  end

  assign out_valid = out_valid_q;
  assign result    = result_q;
  assign ovf       = ovf_q;
  assign acc       = acc_q;

endmodule

// File: doc/tt_accum_unit.md
Name: tt_accum_unit

Overview:
- Parametrised, pipelined successor to the tile's combinational byte adder.
- Accepts operand pairs over a valid/ready handshake and performs add, subtract, accumulate or clear.
- Supports optional saturation and reports overflow.
- Sits behind the TinyTapeout top-level pin mapping:
  - ui_in/uio_in feed the operands.
  - uo_out carries the result.

Parameters:
- WIDTH, 8: operand and result width in bits.
- ACC_WIDTH, 16: accumulator width in bits; must be >= WIDTH+1.

Ports:
- clk  in  1  clock; all state on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- ena  in  1  global enable; low freezes all state.
- in_valid  in  1  operand pair and op are valid.
- in_ready  out  1  unit can accept the presented operation this cycle.
- op  in  2  0=ADD, 1=SUB, 2=ACC, 3=CLR.
- sat_en  in  1  saturate instead of wrap (sampled with the operands).
- a  in  WIDTH  operand A, unsigned.
- b  in  WIDTH  operand B, unsigned.
- out_valid  out  1  result/ovf valid.
- out_ready  in  1  consumer accepts the result.
- result  out  WIDTH  operation result.
- ovf  out  1  carry/borrow/accumulator overflow for this result.
- acc  out  ACC_WIDTH  current accumulator value (registered).

Behaviour:
- Reset (async assert, sync-to-clk release irrelevant): s1_valid=0, out_valid=0, result=0, ovf=0, acc=0.
- in_ready is combinational: ena && (!s1_valid || advance), where advance = ena && s1_valid && (!out_valid || out_ready).
- Two stages:
  - S1 captures {op, sat_en, a, b} on accept (in_valid && in_ready).
  - S2 (output register) computes and loads on advance.
  - Latency: accept in cycle N -> out_valid in cycle N+2 when no backpressure.
  - Throughput: 1 op/cycle.
- Output hold: when out_valid && !out_ready, result/ovf/out_valid hold stable; S1 holds; in_ready=0 if S1 is full.
- If out_ready && !advance, out_valid clears next cycle.
- ena=0: no accept, no advance, no acc change; out_valid/result hold; in_ready=0.
- Arithmetic is unsigned:
  - ADD: sum = a+b at WIDTH+1 bits; ovf = sum[WIDTH]; result = sat_en&&ovf ? all-ones : sum[WIDTH-1:0].
  - SUB: ovf = (a<b) (borrow); result = sat_en&&ovf ? 0 : (a-b) mod 2^WIDTH.
  - ACC: nxt = acc + a + b at ACC_WIDTH+1 bits.
    - ovf = nxt[ACC_WIDTH].
    - acc <= sat_en&&ovf ? ACC all-ones : nxt[ACC_WIDTH-1:0].
    - result = low WIDTH bits of the new acc, or WIDTH all-ones if sat_en and the new acc >= 2^WIDTH.
  - CLR: acc <= 0, result=0, ovf=0.
- acc changes only on advance of an ACC or CLR op. Ops complete strictly in order, so an ACC directly after a CLR sees acc=0.
- ADD/SUB never modify acc.
- Reset mid-operation discards S1 and S2 contents immediately; no partial result is emitted.

Decomposition:
- Package tt_accum_pkg holds:
  - The op_e typedef (OP_ADD=2'd0, OP_SUB=2'd1, OP_ACC=2'd2, OP_CLR=2'd3).
  - A localparam for the opcode width.
- One sub-module, tt_sat_addsub. It is combinational, parametrised by width, and takes operands, subtract flag and sat_en; it returns the value and the carry/borrow.
  - Instantiated twice: WIDTH for ADD/SUB, ACC_WIDTH for ACC.

Test Plan:
- Reset/idle: assert rst_n=0 mid-stream with S1 and S2 full -> same cycle out_valid=0, acc=0, result=0. After release with ena=1 -> in_ready=1.
- ADD wrap vs saturate, WIDTH=8:
  - a=200, b=100, sat_en=0 -> result=44, ovf=1, 2 cycles after accept.
  - Same operands with sat_en=1 -> result=255, ovf=1.
  - a=3, b=4 -> 7, ovf=0.
- SUB borrow:
  - a=5, b=9, sat_en=0 -> result=252, ovf=1.
  - sat_en=1 -> result=0, ovf=1.
- Accumulate sequence: CLR, then ACC(100,100), ACC(100,100), ACC(30,0) back-to-back.
  - acc: 0 -> 200 -> 400 -> 430.
  - results with sat_en=0: 0, 200, 144, 174.
  - Final ACC with sat_en=1 -> 255.
  - ACC_WIDTH=16: acc=65530 + ACC(10,0), sat_en=1 -> acc=65535, ovf=1. With sat_en=0 -> acc=4, ovf=1.
- Backpressure: stream 4 ADDs with out_ready low for 3 cycles.
  - out_valid/result hold stable, in_ready drops once S1 is full, and no op is lost or duplicated.
  - Outputs appear in order after out_ready rises.
- Enable gating: drop ena for 2 cycles mid-stream -> in_ready=0 and acc/out_valid/result frozen; the stream resumes correctly with ena=1.
